// File: rtl/dequant_zigzag_if.sv
// Stream, quant-table and IDCT-side signals of the dequant_zigzag block.
// The master side is the block's environment, and the slave side is the block itself.
interface dequant_zigzag_if #(
    parameter int QC_W  = 12,
    parameter int Q_W   = 8,
    parameter int OUT_W = 16
) ();
    logic                    qt_we;
    logic [5:0]              qt_addr;
    logic [Q_W-1:0]          qt_data;
    logic                    coef_valid;
    logic                    coef_ready;
    logic signed [QC_W-1:0]  coef_data;
    logic                    coef_eob;
    logic                    idct_we;
    logic [5:0]              idct_addr;
    logic signed [OUT_W-1:0] idct_data;
    logic                    idct_start;
    logic                    idct_done;
    logic                    busy;

    modport master (
        output qt_we, qt_addr, qt_data, coef_valid, coef_data, coef_eob, idct_done,
        input  coef_ready, idct_we, idct_addr, idct_data, idct_start, busy
    );

    modport slave (
        input  qt_we, qt_addr, qt_data, coef_valid, coef_data, coef_eob, idct_done,
        output coef_ready, idct_we, idct_addr, idct_data, idct_start, busy
    );
endinterface

// File: rtl/dequant_zigzag.sv
// Dequantises one zigzag-ordered 8x8 coefficient block into the idct8x8 input RAM.
// It zero-fills the block after an early EOB, pulses start, and then waits for done.
module dequant_zigzag #(
    parameter int QC_W  = 12,
    parameter int Q_W   = 8,
    parameter int OUT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    dequant_zigzag_if.slave bus
);
    localparam int P_W = QC_W + Q_W + 1;

    typedef enum logic [1:0] {S_ACCEPT, S_FILL, S_START, S_WAIT} state_t;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [5:0]              r_k;
    logic [5:0]              w_k_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic [Q_W-1:0]          r_qt [64];

    logic                    w_ready;
    logic                    w_acc;
    logic                    w_qt_wr;
    logic signed [P_W-1:0]   w_a;
    logic signed [P_W-1:0]   w_b;
    logic signed [P_W-1:0]   w_prod;
    logic [P_W-OUT_W:0]      w_hi;
    logic signed [OUT_W-1:0] w_sat;

    logic                    w_we;
    logic [5:0]              w_addr;
    logic signed [OUT_W-1:0] w_data;
    logic                    w_start;
    logic                    r_we;
    logic [5:0]              r_addr;
    logic signed [OUT_W-1:0] r_data;
    logic                    r_start;

    assign w_ready = (r_state == S_ACCEPT) && !rst;
    assign w_acc   = w_ready && bus.coef_valid;
    assign w_qt_wr = bus.qt_we && !rst && !r_busy && (r_state == S_ACCEPT);

    // The product fits in P_W bits. It saturates when the bits above the output sign bit
    // are not all copies of that sign bit.
    always_comb begin
        w_a    = P_W'(bus.coef_data);
        w_b    = P_W'(r_qt[r_k]);
        w_prod = w_a * w_b;
        w_hi   = w_prod[P_W-1:OUT_W-1];
        if (w_hi == '0 || w_hi == '1)
            w_sat = w_prod[OUT_W-1:0];
        else if (w_prod[P_W-1])
            w_sat = {1'b1, {(OUT_W-1){1'b0}}};
        else
            w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCEPT;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_busy  <= w_busy_nxt;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_start <= w_start;
        end
    end

    // The table keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (w_qt_wr)
            r_qt[bus.qt_addr] <= bus.qt_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_ACCEPT: begin
                if (w_acc) begin
                    w_k_nxt    = r_k + 6'd1;
                    w_busy_nxt = 1'b1;
                    if (r_k == 6'd63)
                        w_state_nxt = S_START;
                    else if (bus.coef_eob)
                        w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                w_k_nxt = r_k + 6'd1;
                if (r_k == 6'd63)
                    w_state_nxt = S_START;
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.idct_done) begin
                    w_state_nxt = S_ACCEPT;
                    w_k_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_ACCEPT;
        endcase
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = ZZ[r_k];
        w_data  = '0;
        w_start = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                w_we   = w_acc;
                w_data = w_acc ? w_sat : '0;
            end
            S_FILL:  w_we    = 1'b1;
            S_START: w_start = 1'b1;
            default: w_we    = 1'b0;
        endcase
        if (!w_we)
            w_addr = r_addr;
    end

    assign bus.coef_ready = w_ready;
    assign bus.idct_we    = r_we;
    assign bus.idct_addr  = r_addr;
    assign bus.idct_data  = r_data;
    assign bus.idct_start = r_start;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_dequant_zigzag.sv
// Directed bench for dequant_zigzag: covers zigzag addressing, scaling, saturation and zero-fill.
// It also covers backpressure, quant-table write protection and reset in the middle of a block.
module tb_dequant_zigzag;
    localparam int QC_W  = 12;
    localparam int Q_W   = 8;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dequant_zigzag_if #(.QC_W(QC_W), .Q_W(Q_W), .OUT_W(OUT_W)) bus ();

    dequant_zigzag #(.QC_W(QC_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int coef;
        int q;
        int exp;
    } vec_t;

    int ZZ [64] = '{
        0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_n = 0;
    int start_n = 0;
    int last_we_cyc = 0;
    int start_cyc = 0;
    int wr_addr [4096];
    int wr_data [4096];
    int exp_img [64];
    int blk_wr = 0;
    int blk_st = 0;

    // Log of every IDCT RAM write and every start pulse, sampled just after the clock edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.idct_we === 1'b1) begin
            if (wr_n < 4096) begin
                wr_addr[wr_n] = int'(bus.idct_addr);
                wr_data[wr_n] = int'(bus.idct_data);
            end
            wr_n++;
            last_we_cyc = cyc;
        end
        if (bus.idct_start === 1'b1) begin
            start_n++;
            start_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic qt_write(input int idx, input int val);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        bus.qt_we      = 1'b1;
        bus.qt_addr    = 6'(idx);
        bus.qt_data    = Q_W'(val);
        @(negedge clk);
        bus.qt_we      = 1'b0;
    endtask

    // Returns at the clock edge that accepts the beat and leaves coef_valid high.
    task automatic send_beat(input int c, input bit eob);
        int n;
        n = 0;
        @(negedge clk);
        bus.coef_valid = 1'b1;
        bus.coef_data  = QC_W'(c);
        bus.coef_eob   = eob;
        #1;
        while (bus.coef_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("beat_accepted", int'(n < 200), 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.coef_valid = 1'b0;
        bus.coef_eob   = 1'b0;
    endtask

    task automatic begin_block();
        blk_wr = wr_n;
        blk_st = start_n;
        for (int i = 0; i < 64; i++) exp_img[i] = 0;
    endtask

    task automatic wait_block_end(input int wait_cycles, input string tag);
        int n;
        int idx;
        n = 0;
        while (start_n == blk_st && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " start_seen"}, int'(start_n != blk_st), 1);
        chk({tag, " write_count"}, wr_n - blk_wr, 64);
        chk({tag, " start_gap"}, start_cyc - last_we_cyc, 1);
        for (int i = 0; i < 64; i++) begin
            idx = blk_wr + i;
            if (idx < 4096) begin
                chk({tag, " addr"}, wr_addr[idx], ZZ[i]);
                chk({tag, " data"}, wr_data[idx], exp_img[ZZ[i]]);
            end
        end
        #1;
        chk({tag, " wait_ready"}, int'(bus.coef_ready), 0);
        chk({tag, " wait_busy"}, int'(bus.busy), 1);
        repeat (wait_cycles) @(negedge clk);
        #1;
        chk({tag, " held_ready"}, int'(bus.coef_ready), 0);
        chk({tag, " held_writes"}, wr_n - blk_wr, 64);
        @(negedge clk);
        bus.idct_done = 1'b1;
        @(negedge clk);
        bus.idct_done = 1'b0;
        #1;
        chk({tag, " done_ready"}, int'(bus.coef_ready), 1);
        chk({tag, " done_busy"}, int'(bus.busy), 0);
        chk({tag, " start_pulses"}, start_n - blk_st, 1);
    endtask

    vec_t vecs [12];
    int   w_snap;
    int   s_snap;

    initial begin
        vecs[0]  = '{coef: 1024,  q: 1,   exp: 1024};
        vecs[1]  = '{coef: 2047,  q: 255, exp: 32767};
        vecs[2]  = '{coef: -2048, q: 255, exp: -32768};
        vecs[3]  = '{coef: -1,    q: 255, exp: -255};
        vecs[4]  = '{coef: 500,   q: 2,   exp: 1000};
        vecs[5]  = '{coef: -7,    q: 3,   exp: -21};
        vecs[6]  = '{coef: 2047,  q: 16,  exp: 32752};
        vecs[7]  = '{coef: 2047,  q: 17,  exp: 32767};
        vecs[8]  = '{coef: -2048, q: 16,  exp: -32768};
        vecs[9]  = '{coef: -2048, q: 17,  exp: -32768};
        vecs[10] = '{coef: 0,     q: 255, exp: 0};
        vecs[11] = '{coef: 100,   q: 0,   exp: 0};

        bus.qt_we      = 1'b0;
        bus.qt_addr    = '0;
        bus.qt_data    = '0;
        bus.coef_valid = 1'b0;
        bus.coef_data  = '0;
        bus.coef_eob   = 1'b0;
        bus.idct_done  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst ready", int'(bus.coef_ready), 0);
        chk("rst we", int'(bus.idct_we), 0);
        chk("rst addr", int'(bus.idct_addr), 0);
        chk("rst data", int'(bus.idct_data), 0);
        chk("rst start", int'(bus.idct_start), 0);
        chk("rst busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst ready", int'(bus.coef_ready), 1);

        // DC-only block with an all-ones table
        for (int i = 0; i < 64; i++) qt_write(i, 1);
        begin_block();
        exp_img[0] = 1024;
        send_beat(1024, 1'b1);
        idle();
        wait_block_end(3, "t1");

        // Full block: zigzag addressing with qt[k] = k+1
        for (int k = 0; k < 64; k++) qt_write(k, k + 1);
        begin_block();
        for (int k = 0; k < 64; k++) exp_img[ZZ[k]] = k + 1;
        for (int k = 0; k < 64; k++) send_beat(1, 1'b0);
        idle();
        #1;
        chk("t2 ready_drop", int'(bus.coef_ready), 0);
        wait_block_end(2, "t2");

        // Scaling of AC terms with early EOB
        qt_write(1, 2);
        qt_write(2, 3);
        begin_block();
        exp_img[1] = 1000;
        exp_img[8] = -21;
        send_beat(0, 1'b0);
        send_beat(500, 1'b0);
        send_beat(-7, 1'b1);
        idle();
        wait_block_end(1, "t3");

        for (int v = 0; v < 12; v++) begin
            qt_write(0, vecs[v].q);
            begin_block();
            exp_img[0] = vecs[v].exp;
            send_beat(vecs[v].coef, 1'b1);
            idle();
            wait_block_end(1, "vec");
        end

        // The protected table write is ignored, and valid is held through FILL and WAIT.
        qt_write(0, 255);
        begin_block();
        exp_img[0] = 255;
        send_beat(1, 1'b0);
        #1;
        chk("t5 busy_after_first", int'(bus.busy), 1);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        bus.qt_we      = 1'b1;
        bus.qt_addr    = 6'd0;
        bus.qt_data    = Q_W'(9);
        @(negedge clk);
        bus.qt_we      = 1'b0;
        send_beat(0, 1'b1);
        @(negedge clk);
        bus.coef_valid = 1'b1;
        bus.coef_data  = QC_W'(1);
        bus.coef_eob   = 1'b1;
        bus.idct_done  = 1'b1;
        @(negedge clk);
        bus.idct_done  = 1'b0;
        #1;
        chk("t5 fill_ready", int'(bus.coef_ready), 0);
        wait_block_end(5, "t5a");
        begin_block();
        exp_img[0] = 255;
        @(posedge clk);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        bus.coef_eob   = 1'b0;
        wait_block_end(1, "t5b");

        // Reset in the middle of a block
        for (int i = 0; i < 10; i++) send_beat(1, 1'b0);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6 rst we", int'(bus.idct_we), 0);
        chk("t6 rst addr", int'(bus.idct_addr), 0);
        chk("t6 rst data", int'(bus.idct_data), 0);
        chk("t6 rst start", int'(bus.idct_start), 0);
        chk("t6 rst busy", int'(bus.busy), 0);
        chk("t6 rst ready", int'(bus.coef_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6 ready_after", int'(bus.coef_ready), 1);
        w_snap = wr_n;
        s_snap = start_n;
        repeat (20) @(negedge clk);
        chk("t6 no_writes", wr_n - w_snap, 0);
        chk("t6 no_start", start_n - s_snap, 0);
        begin_block();
        exp_img[0] = 510;
        send_beat(2, 1'b1);
        idle();
        wait_block_end(1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
